// File: rtl/hash_lookup.sv
// Exact-match lookup requester: hands a key to the byte-fold hash unit, then probes a
// linear-probing key/action table from the returned index. Optional stats: LOOKUP_STATS_EN.
module hash_lookup #(
  parameter int INDEX_W      = 8,
  parameter int ACTION_W     = 32,
  parameter int PROBE_MAX    = 4,
  parameter int HASH_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [63:0]         req_key_i,
  output logic                hash_start_o,
  output logic [63:0]         hash_key_o,
  input  logic                hash_ready_i,
  input  logic [31:0]         hash_val_i,
  output logic                rsp_valid_o,
  output logic                rsp_hit_o,
  output logic                rsp_err_o,
  output logic [ACTION_W-1:0] rsp_action_o,
  output logic [INDEX_W-1:0]  rsp_index_o,
  input  logic                cfg_we_i,
  input  logic [INDEX_W-1:0]  cfg_addr_i,
  input  logic                cfg_valid_i,
  input  logic [63:0]         cfg_key_i,
  input  logic [ACTION_W-1:0] cfg_action_i,
  output logic [2:0]          dbg_state_o
`ifdef LOOKUP_STATS_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o,
  output logic [31:0]         err_cnt_o
`endif
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int CNT_W = (PROBE_MAX > 1) ? $clog2(PROBE_MAX) : 1;
  localparam int TMO_W = (HASH_TIMEOUT > 1) ? $clog2(HASH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] PROBE_LAST = CNT_W'(PROBE_MAX - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(HASH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_LO, S_WAIT_HI, S_PROBE, S_DONE
  } state_t;

  // Handshakes: a request transfers on a rising edge where req_valid_i & req_ready_o;
  // a hash result is taken only after hash_ready_i has been seen low then high.
  state_t               r_state;
  logic                 r_req_ready;
  logic                 r_hash_start;
  logic [63:0]          r_hash_key;
  logic [INDEX_W-1:0]   r_idx;
  logic [CNT_W-1:0]     r_probe_cnt;
  logic [TMO_W-1:0]     r_tmo;
  logic                 r_rsp_valid;
  logic                 r_rsp_hit;
  logic                 r_rsp_err;
  logic [ACTION_W-1:0]  r_rsp_action;
  logic [INDEX_W-1:0]   r_rsp_index;

  logic [DEPTH-1:0]     r_valid;
  logic [63:0]          r_key [DEPTH];
  logic [ACTION_W-1:0]  r_act [DEPTH];

  logic                 w_entry_valid;
  logic                 w_hit;
  logic                 w_unused_hash;

  // Table reads see pre-write contents, so a same-cycle cfg write never alters a compare.
  assign w_entry_valid = r_valid[r_idx];
  assign w_hit         = w_entry_valid && (r_key[r_idx] == r_hash_key);
  assign w_unused_hash = ^hash_val_i[31:INDEX_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (cfg_we_i) begin
      r_valid[cfg_addr_i] <= cfg_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we_i) begin
      r_key[cfg_addr_i] <= cfg_key_i;
      r_act[cfg_addr_i] <= cfg_action_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_hash_start <= 1'b0;
      r_hash_key   <= '0;
      r_idx        <= '0;
      r_probe_cnt  <= '0;
      r_tmo        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_action <= '0;
      r_rsp_index  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i && r_req_ready) begin
            r_hash_key   <= req_key_i;
            r_hash_start <= 1'b1;
            r_req_ready  <= 1'b0;
            r_tmo        <= '0;
            r_state      <= S_START;
          end
        end
        S_START, S_WAIT_LO: begin
          if (r_tmo == TMO_LAST) begin
            r_hash_start <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (r_state == S_START && !hash_ready_i) r_state <= S_WAIT_LO;
            if (r_state == S_WAIT_LO && hash_ready_i) r_state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          r_idx        <= hash_val_i[INDEX_W-1:0];
          r_hash_start <= 1'b0;
          r_probe_cnt  <= '0;
          r_state      <= S_PROBE;
        end
        S_PROBE: begin
          if (w_hit) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_hit    <= 1'b1;
            r_rsp_action <= r_act[r_idx];
            r_rsp_index  <= r_idx;
            r_state      <= S_DONE;
          end else if (!w_entry_valid || r_probe_cnt == PROBE_LAST) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx       <= r_idx + 1'b1;
            r_probe_cnt <= r_probe_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_rsp_valid  <= 1'b0;
          r_rsp_hit    <= 1'b0;
          r_rsp_err    <= 1'b0;
          r_rsp_action <= '0;
          r_rsp_index  <= '0;
          if (!hash_ready_i) begin
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = r_req_ready;
  assign hash_start_o = r_hash_start;
  assign hash_key_o   = r_hash_key;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_hit_o    = r_rsp_hit;
  assign rsp_err_o    = r_rsp_err;
  assign rsp_action_o = r_rsp_action;
  assign rsp_index_o  = r_rsp_index;
  assign dbg_state_o  = r_state;

`ifdef LOOKUP_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt, r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (r_rsp_valid) begin
      if (r_rsp_err) begin
        if (r_err_cnt != 32'hFFFF_FFFF) r_err_cnt <= r_err_cnt + 1'b1;
      end else if (r_rsp_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 1'b1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
  assign err_cnt_o  = r_err_cnt;
`endif

endmodule

// File: tb/tb_hash_lookup.sv
// Bench for hash_lookup: a scripted hash-unit model plus a table/probe reference model
// built from plain arrays; directed cases followed by randomized lookups.
module tb_hash_lookup;

  localparam int INDEX_W   = 8;
  localparam int ACTION_W  = 32;
  localparam int PROBE_MAX = 4;
  localparam int DEPTH     = 1 << INDEX_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  logic [63:0]         req_key_i = '0;
  logic                hash_start_o;
  logic [63:0]         hash_key_o;
  logic                hash_ready_i = 1'b0;
  logic [31:0]         hash_val_i = '0;
  logic                rsp_valid_o;
  logic                rsp_hit_o;
  logic                rsp_err_o;
  logic [ACTION_W-1:0] rsp_action_o;
  logic [INDEX_W-1:0]  rsp_index_o;
  logic                cfg_we_i = 1'b0;
  logic [INDEX_W-1:0]  cfg_addr_i = '0;
  logic                cfg_valid_i = 1'b0;
  logic [63:0]         cfg_key_i = '0;
  logic [ACTION_W-1:0] cfg_action_i = '0;
  logic [2:0]          dbg_state_o;

  hash_lookup #(.INDEX_W(INDEX_W), .ACTION_W(ACTION_W), .PROBE_MAX(PROBE_MAX), .HASH_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_key_i(req_key_i),
    .hash_start_o(hash_start_o), .hash_key_o(hash_key_o),
    .hash_ready_i(hash_ready_i), .hash_val_i(hash_val_i),
    .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_err_o(rsp_err_o),
    .rsp_action_o(rsp_action_o), .rsp_index_o(rsp_index_o),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
    .cfg_key_i(cfg_key_i), .cfg_action_i(cfg_action_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- hash unit model ----------------
  // mode 0: ready 3 cycles after start; 1: never ready; 2: stale ready held, then low, then new
  int          h_mode = 0;
  int          h_cnt  = 0;
  logic [31:0] h_val   = '0;
  logic [31:0] h_stale = '0;

  always @(posedge clk) begin
    #2;
    if (h_mode == 1) begin
      hash_ready_i = 1'b0;
    end else if (h_mode == 2) begin
      if (hash_start_o) h_cnt++;
      if (h_cnt == 0 || (hash_start_o && h_cnt <= 3)) begin
        hash_ready_i = 1'b1; hash_val_i = h_stale;
      end else if (hash_start_o && h_cnt >= 6) begin
        hash_ready_i = 1'b1; hash_val_i = h_val;
      end else begin
        hash_ready_i = 1'b0;
      end
    end else begin
      if (hash_start_o) begin
        if (h_cnt < 3) h_cnt++;
        if (h_cnt == 3) begin hash_ready_i = 1'b1; hash_val_i = h_val; end
      end else begin
        h_cnt = 0; hash_ready_i = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  bit          m_valid [DEPTH];
  logic [63:0] m_key   [DEPTH];
  logic [31:0] m_act   [DEPTH];

  function automatic void ref_lookup(input logic [7:0] h, input logic [63:0] key,
                                     output bit hit, output logic [7:0] idx,
                                     output logic [31:0] act, output int probes);
    logic [7:0] a;
    hit = 0; idx = '0; act = '0; probes = 0;
    for (int p = 0; p < PROBE_MAX; p++) begin
      a = h + 8'(p);
      probes = p + 1;
      if (!m_valid[a]) break;
      if (m_key[a] == key) begin hit = 1; idx = a; act = m_act[a]; break; end
    end
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic [7:0] a, input bit v, input logic [63:0] k, input logic [31:0] act);
    @(negedge clk);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_valid_i = v; cfg_key_i = k; cfg_action_i = act;
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
    m_valid[a] = v; m_key[a] = k; m_act[a] = act;
  endtask

  bit          g_got;
  int          g_lat;
  logic        g_hit, g_err;
  logic [31:0] g_act;
  logic [7:0]  g_idx;

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready_o) begin ok = 1; break; end
    end
    check({tag, "_back_to_idle"}, 64'(ok), 64'd1);
  endtask

  task automatic lookup(input string tag, input logic [63:0] key);
    @(negedge clk);
    check({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_key_i = key;
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_key_i = $urandom();
    check({tag, "_hash_key"}, hash_key_o, key);
    g_got = 0; g_lat = 0; g_hit = 0; g_err = 0; g_act = '0; g_idx = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        g_got = 1; g_lat = c;
        g_hit = rsp_hit_o; g_err = rsp_err_o; g_act = rsp_action_o; g_idx = rsp_index_o;
        break;
      end
    end
    check({tag, "_rsp_seen"}, 64'(g_got), 64'd1);
    @(negedge clk);
    check({tag, "_pulse_end"}, {rsp_valid_o, rsp_hit_o, rsp_err_o, rsp_action_o, rsp_index_o}, 64'd0);
    wait_idle(tag);
  endtask

  task automatic lookup_vs_model(input string tag, input logic [63:0] key, input logic [7:0] h, input int lat1);
    bit e_hit; logic [7:0] e_idx; logic [31:0] e_act; int e_probes;
    ref_lookup(h, key, e_hit, e_idx, e_act, e_probes);
    h_val = {$urandom_range(0, 255), 16'h0, h};
    lookup(tag, key);
    check({tag, "_hit"},    64'(g_hit), 64'(e_hit));
    check({tag, "_err"},    64'(g_err), 64'd0);
    check({tag, "_action"}, 64'(g_act), 64'(e_act));
    check({tag, "_index"},  64'(g_idx), 64'(e_idx));
    if (lat1 > 0) check({tag, "_latency"}, 64'(g_lat), 64'(lat1 + e_probes - 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat1, cnt;
    bit saw, ok;
    logic [63:0] ks [4];

    for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_key[i] = '0; m_act[i] = '0; end
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {req_ready_o, hash_start_o, rsp_valid_o, rsp_hit_o, rsp_err_o, rsp_action_o, rsp_index_o},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0});
    check("reset_hash_key", hash_key_o, 64'd0);
    rst = 1'b0;

    // direct hit on the first probe
    cfg_write(8'h24, 1, 64'h0102030405060708, 32'hAA55);
    lookup_vs_model("hit1", 64'h0102030405060708, 8'h24, 0);
    check("hit1_hit_const", 64'(g_hit), 64'd1);
    check("hit1_index_const", 64'(g_idx), 64'h24);
    lat1 = g_lat;

    // second probe
    cfg_write(8'h24, 1, 64'h1111, 32'h7);
    cfg_write(8'h25, 1, 64'h2222, 32'h1);
    lookup_vs_model("probe2", 64'h2222, 8'h24, lat1);

    // wrap from 0xFF to 0x00
    cfg_write(8'hFF, 1, 64'h3333, 32'h9);
    cfg_write(8'h00, 1, 64'h4444, 32'h55);
    lookup_vs_model("wrap", 64'h4444, 8'hFF, lat1);

    // probe limit: five valid non-matching entries
    for (int i = 0; i < 5; i++) cfg_write(8'h10 + 8'(i), 1, 64'hDEAD_0000 + 64'(i), 32'h100 + 32'(i));
    lookup_vs_model("probe_max", 64'hBEEF, 8'h10, lat1);
    check("probe_max_lat_const", 64'(g_lat), 64'(lat1 + 3));

    // hash timeout
    h_mode = 1;
    @(negedge clk);
    req_valid_i = 1'b1; req_key_i = 64'h5555;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    cnt = 0; ok = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!hash_start_o) begin ok = 1; break; end
      cnt++;
    end
    check("tmo_start_dropped", 64'(ok), 64'd1);
    check("tmo_start_cycles", 64'(cnt), 64'd16);
    check("tmo_rsp", {rsp_valid_o, rsp_err_o, rsp_hit_o}, {1'b1, 1'b1, 1'b0});
    h_mode = 0;
    wait_idle("tmo");

    // reset while waiting in WAIT_HI
    h_val = 32'h24;
    @(negedge clk);
    req_valid_i = 1'b1; req_key_i = 64'h0102030405060708;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (hash_ready_i) begin ok = 1; break; end
    end
    check("rstmid_ready_seen", 64'(ok), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstmid_outputs",
          {req_ready_o, hash_start_o, rsp_valid_o, rsp_hit_o, rsp_err_o, rsp_action_o, rsp_index_o},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0});
    check("rstmid_hash_key", hash_key_o, 64'd0);
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid_o) saw = 1;
    end
    check("rstmid_no_rsp", 64'(saw), 64'd0);
    lookup_vs_model("after_rst_miss", 64'h0102030405060708, 8'h24, 0);

    // stale ready held high before the request
    cfg_write(8'h40, 1, 64'h6666, 32'hBAD);
    cfg_write(8'h50, 1, 64'h6666, 32'h600D);
    h_stale = 32'h40; h_cnt = 0; h_mode = 2;
    repeat (2) @(negedge clk);
    h_val = 32'h50;
    lookup("stale", 64'h6666);
    check("stale_hit", 64'(g_hit), 64'd1);
    check("stale_index", 64'(g_idx), 64'h50);
    check("stale_action", 64'(g_act), 64'h600D);
    h_mode = 0;
    repeat (2) @(negedge clk);

    // randomized tables and lookups
    for (int t = 0; t < 4; t++) ks[t] = {$urandom(), $urandom()};
    for (int it = 0; it < 20; it++) begin
      logic [7:0] base;
      base = 8'($urandom_range(0, 255));
      for (int i = 0; i < 6; i++)
        cfg_write(base + 8'(i), ($urandom_range(0, 5) != 0), ks[$urandom_range(0, 3)], $urandom());
      lookup_vs_model($sformatf("rand%0d", it), ks[$urandom_range(0, 3)], base, lat1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
